// File: rtl/pam_rx_analyzer.sv
// Receive-side test packet analyzer: tracks framing of the returning 134-bit
// packet stream, measures one-way latency and keeps per-flow statistics.
module pam_rx_analyzer #(
  parameter int unsigned FLOW_NUM = 8,
  parameter int unsigned TS_W     = 48,
  parameter logic [31:0] LAT_SAT  = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cnt_rst,
  input  logic [TS_W-1:0]          timestamp,
  input  logic [FLOW_NUM*12-1:0]   in_pam_pkt_len,
  input  logic [133:0]             in_pam_data,
  input  logic                     in_pam_data_wr,
  input  logic                     in_pam_data_valid,
  input  logic                     in_pam_data_valid_wr,
  output logic [FLOW_NUM*32-1:0]   out_pam_pkt_cnt,
  output logic [31:0]              out_pam_len_err_cnt,
  output logic [31:0]              out_pam_fmt_err_cnt,
  output logic [31:0]              out_pam_drop_cnt,
  output logic [31:0]              out_pam_last_lat,
  output logic [31:0]              out_pam_max_lat
);

  localparam int unsigned FID_W = $clog2(FLOW_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BODY,
    S_WAIT,
    S_DISCARD,
    S_COMMIT
  } state_t;

  state_t            state_q;
  logic [FID_W-1:0]  flow_q;
  logic [TS_W-1:0]   tx_ts_q;
  logic [TS_W-1:0]   rx_ts_q;
  logic [11:0]       byte_cnt_q;
  logic [11:0]       byte_cnt_d;
  logic              good_q;

  logic [31:0]       pkt_cnt_q [FLOW_NUM];
  logic [31:0]       len_err_q;
  logic [31:0]       fmt_err_q;
  logic [31:0]       drop_q;
  logic [31:0]       last_lat_q;
  logic [31:0]       max_lat_q;

  logic              is_head;
  logic              is_mid;
  logic              is_tail;
  logic              fmt_inc;
  logic              commit_good;
  logic              commit_drop;
  logic [4:0]        add_bytes;
  logic [12:0]       byte_sum;
  logic [TS_W-1:0]   lat_full;
  logic [31:0]       lat_d;
  logic [11:0]       cfg_len;
  logic              unused_bits;

  assign unused_bits = ^{in_pam_data[127:TS_W+64], in_pam_data[63:FID_W]};

  // The commit cycle handles incoming words exactly like IDLE, which is what
  // lets a head directly after a committed packet start with no bubble.
  always_comb begin
    is_head     = in_pam_data_wr && (in_pam_data[133:132] == 2'b01);
    is_mid      = in_pam_data_wr && (in_pam_data[133:132] == 2'b11);
    is_tail     = in_pam_data_wr && (in_pam_data[133:132] == 2'b10);
    fmt_inc     = ((state_q == S_IDLE || state_q == S_COMMIT) && (is_mid || is_tail)) ||
                  ((state_q == S_BODY || state_q == S_WAIT) && is_head);
    commit_good = (state_q == S_COMMIT) && good_q;
    commit_drop = (state_q == S_COMMIT) && !good_q;
  end

  always_comb begin
    add_bytes  = is_tail ? (5'd16 - {1'b0, in_pam_data[131:128]}) : 5'd16;
    byte_sum   = {1'b0, byte_cnt_q} + {8'd0, add_bytes};
    byte_cnt_d = byte_sum[12] ? 12'hFFF : byte_sum[11:0];
    lat_full   = rx_ts_q - tx_ts_q;
    lat_d      = (|lat_full[TS_W-1:32]) ? LAT_SAT : lat_full[31:0];
    cfg_len    = '0;
    for (int unsigned k = 0; k < FLOW_NUM; k++) begin
      if (flow_q == FID_W'(k)) cfg_len = in_pam_pkt_len[k*12 +: 12];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      flow_q     <= '0;
      tx_ts_q    <= '0;
      rx_ts_q    <= '0;
      byte_cnt_q <= '0;
      good_q     <= 1'b0;
    end else if (is_head) begin
      // A head always opens a new packet; any packet in flight is abandoned.
      state_q    <= S_BODY;
      flow_q     <= in_pam_data[FID_W-1:0];
      tx_ts_q    <= in_pam_data[64 +: TS_W];
      rx_ts_q    <= timestamp;
      byte_cnt_q <= 12'd16;
    end else begin
      case (state_q)
        S_IDLE, S_COMMIT: state_q <= is_mid ? S_DISCARD : S_IDLE;
        S_BODY: begin
          if (is_mid) begin
            byte_cnt_q <= byte_cnt_d;
          end else if (is_tail) begin
            byte_cnt_q <= byte_cnt_d;
            if (in_pam_data_valid_wr) begin
              good_q  <= in_pam_data_valid;
              state_q <= S_COMMIT;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (in_pam_data_valid_wr) begin
            good_q  <= in_pam_data_valid;
            state_q <= S_COMMIT;
          end
        end
        S_DISCARD: if (is_tail) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_rst) begin
      for (int unsigned k = 0; k < FLOW_NUM; k++) pkt_cnt_q[k] <= '0;
      len_err_q  <= '0;
      fmt_err_q  <= '0;
      drop_q     <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
    end else begin
      if (fmt_inc)     fmt_err_q <= fmt_err_q + 32'd1;
      if (commit_drop) drop_q    <= drop_q + 32'd1;
      if (commit_good) begin
        pkt_cnt_q[flow_q] <= pkt_cnt_q[flow_q] + 32'd1;
        if (byte_cnt_q != cfg_len) len_err_q <= len_err_q + 32'd1;
        last_lat_q <= lat_d;
        if (lat_d > max_lat_q) max_lat_q <= lat_d;
      end
    end
  end

  always_comb begin
    out_pam_pkt_cnt = '0;
    for (int unsigned k = 0; k < FLOW_NUM; k++) begin
      out_pam_pkt_cnt[k*32 +: 32] = pkt_cnt_q[k];
    end
  end

  assign out_pam_len_err_cnt = len_err_q;
  assign out_pam_fmt_err_cnt = fmt_err_q;
  assign out_pam_drop_cnt    = drop_q;
  assign out_pam_last_lat    = last_lat_q;
  assign out_pam_max_lat     = max_lat_q;

endmodule

// File: tb/tb_pam_rx_analyzer.sv
// Scoreboard bench for pam_rx_analyzer: packet-level reference model feeds an
// expectation queue that a negedge monitor compares against the DUT.
module tb_pam_rx_analyzer;

  logic          clk = 1'b0;
  logic          rst;
  logic          cnt_rst;
  logic [47:0]   timestamp;
  logic [95:0]   in_pam_pkt_len;
  logic [133:0]  in_pam_data;
  logic          in_pam_data_wr;
  logic          in_pam_data_valid;
  logic          in_pam_data_valid_wr;
  logic [255:0]  out_pam_pkt_cnt;
  logic [31:0]   out_pam_len_err_cnt;
  logic [31:0]   out_pam_fmt_err_cnt;
  logic [31:0]   out_pam_drop_cnt;
  logic [31:0]   out_pam_last_lat;
  logic [31:0]   out_pam_max_lat;

  pam_rx_analyzer #(.FLOW_NUM(8), .TS_W(48), .LAT_SAT(32'hFFFF_FFFF)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cnt_rst             (cnt_rst),
    .timestamp           (timestamp),
    .in_pam_pkt_len      (in_pam_pkt_len),
    .in_pam_data         (in_pam_data),
    .in_pam_data_wr      (in_pam_data_wr),
    .in_pam_data_valid   (in_pam_data_valid),
    .in_pam_data_valid_wr(in_pam_data_valid_wr),
    .out_pam_pkt_cnt     (out_pam_pkt_cnt),
    .out_pam_len_err_cnt (out_pam_len_err_cnt),
    .out_pam_fmt_err_cnt (out_pam_fmt_err_cnt),
    .out_pam_drop_cnt    (out_pam_drop_cnt),
    .out_pam_last_lat    (out_pam_last_lat),
    .out_pam_max_lat     (out_pam_max_lat)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned  due;
    logic [255:0] pkt;
    logic [31:0]  len_err;
    logic [31:0]  fmt;
    logic [31:0]  drop;
    logic [31:0]  last_lat;
    logic [31:0]  max_lat;
  } snap_t;

  snap_t        exp_q[$];
  int unsigned  errors = 0;
  int unsigned  checks = 0;

  // Reference model state: statistics as the packet rules define them.
  logic [31:0]  m_pkt [8];
  logic [31:0]  m_len, m_fmt, m_drop, m_last, m_max;
  logic [11:0]  cfg [8];
  int unsigned  cfg_m [8];
  logic [3:0]   cfg_inv [8];
  logic [47:0]  ts_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) m_pkt[k] = '0;
    m_len = '0; m_fmt = '0; m_drop = '0; m_last = '0; m_max = '0;
  endtask

  task automatic model_commit(input logic [2:0] flow, input int unsigned len, input logic vld,
                              input logic [47:0] tx, input logic [47:0] rx);
    logic [47:0] d;
    logic [31:0] lat;
    int unsigned blen;
    if (!vld) begin
      m_drop = m_drop + 32'd1;
    end else begin
      blen = (len > 4095) ? 4095 : len;
      m_pkt[flow] = m_pkt[flow] + 32'd1;
      if (12'(blen) != cfg[flow]) m_len = m_len + 32'd1;
      d   = rx - tx;
      lat = (d > 48'h0000_FFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
      m_last = lat;
      if (lat > m_max) m_max = lat;
    end
  endtask

  task automatic push_exp(input int unsigned due);
    snap_t s;
    s.due = due;
    for (int k = 0; k < 8; k++) s.pkt[k*32 +: 32] = m_pkt[k];
    s.len_err = m_len; s.fmt = m_fmt; s.drop = m_drop;
    s.last_lat = m_last; s.max_lat = m_max;
    exp_q.push_back(s);
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("due_cycle", cyc, e.due);
        for (int k = 0; k < 8; k++)
          chk($sformatf("pkt_cnt[%0d]", k), out_pam_pkt_cnt[k*32 +: 32], e.pkt[k*32 +: 32]);
        chk("len_err_cnt", out_pam_len_err_cnt, e.len_err);
        chk("fmt_err_cnt", out_pam_fmt_err_cnt, e.fmt);
        chk("drop_cnt",    out_pam_drop_cnt,    e.drop);
        chk("last_lat",    out_pam_last_lat,    e.last_lat);
        chk("max_lat",     out_pam_max_lat,     e.max_lat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    in_pam_data_wr = 1'b0; in_pam_data_valid_wr = 1'b0; in_pam_data_valid = 1'b0;
    cnt_rst = 1'b0; rst = 1'b0;
    ts_now = ts_now + 48'd1;
    timestamp = ts_now;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic apply_cfg();
    for (int k = 0; k < 8; k++) in_pam_pkt_len[k*12 +: 12] = cfg[k];
  endtask

  task automatic send_head(input logic [2:0] flow, input logic [47:0] tx, input logic [47:0] rx);
    logic [127:0] pl;
    pl = rnd128();
    pl[2:0] = flow;
    pl[111:64] = tx;
    ts_now = rx; timestamp = rx;
    in_pam_data = {2'b01, 4'($urandom_range(0, 15)), pl};
    in_pam_data_wr = 1'b1;
    tick();
  endtask

  task automatic send_mid();
    in_pam_data = {2'b11, 4'($urandom_range(0, 15)), rnd128()};
    in_pam_data_wr = 1'b1;
    tick();
  endtask

  task automatic send_tail(input logic [3:0] inv, input logic st, input logic vld,
                           output int unsigned dcyc);
    in_pam_data = {2'b10, inv, rnd128()};
    in_pam_data_wr = 1'b1;
    if (st) begin in_pam_data_valid_wr = 1'b1; in_pam_data_valid = vld; end
    dcyc = cyc;
    tick();
  endtask

  task automatic send_status(input logic vld, output int unsigned dcyc);
    in_pam_data_valid_wr = 1'b1; in_pam_data_valid = vld;
    dcyc = cyc;
    tick();
  endtask

  // One packet: head, nmid middles, tail, then status after `gap` words.
  task automatic full_pkt(input logic [2:0] flow, input int unsigned nmid, input logic [3:0] inv,
                          input logic vld, input int unsigned gap, input logic [47:0] tx,
                          input logic [47:0] rx, output int unsigned scyc);
    send_head(flow, tx, rx);
    repeat (nmid) send_mid();
    send_tail(inv, gap == 0, vld, scyc);
    if (gap > 0) begin
      idle(int'(gap) - 1);
      send_status(vld, scyc);
    end
    model_commit(flow, 32 + 16 * nmid - int'(inv), vld, tx, rx);
  endtask

  function automatic logic [47:0] rand_lat();
    case ($urandom_range(0, 4))
      0:       return 48'($urandom_range(0, 1000));
      1:       return {16'd0, 32'($urandom())};
      2:       return {16'($urandom_range(1, 65535)), 32'($urandom())};
      3:       return 48'h0000_FFFF_FFFF;
      default: return 48'h0001_0000_0000;
    endcase
  endfunction

  task automatic rand_pkt(input logic gap0, output int unsigned sc);
    logic [2:0]  f;
    int unsigned nm;
    logic [3:0]  inv;
    logic [47:0] rx;
    int unsigned gap;
    f = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) begin
      nm = cfg_m[f]; inv = cfg_inv[f];
    end else begin
      nm = $urandom_range(0, 4); inv = 4'($urandom_range(0, 15));
    end
    rx  = ts_now + 48'($urandom_range(1, 50));
    gap = gap0 ? 0 : $urandom_range(0, 2);
    full_pkt(f, nm, inv, $urandom_range(0, 3) != 0, gap, rx - rand_lat(), rx, sc);
  endtask

  initial begin : stimulus
    int unsigned sc, sc2, dc;
    rst = 1'b1; cnt_rst = 1'b0; ts_now = '0; timestamp = '0;
    in_pam_data = '0; in_pam_data_wr = 1'b0;
    in_pam_data_valid = 1'b0; in_pam_data_valid_wr = 1'b0;
    for (int k = 0; k < 8; k++) cfg[k] = '0;
    apply_cfg();
    model_clear();

    dc = 0;
    repeat (3) begin rst = 1'b1; dc = cyc; tick(); end
    push_exp(dc + 1);
    idle(2);

    // Flow 3, 76 bytes, latency 250, configured length matches.
    cfg[3] = 12'd76; apply_cfg();
    full_pkt(3'd3, 3, 4'd4, 1'b1, 0, 48'd1000, 48'd1250, sc);
    push_exp(sc + 2); idle(2);

    // Same packet against 80-byte config, then a dropped packet.
    cnt_rst = 1'b1; dc = cyc; tick(); model_clear(); push_exp(dc + 1); idle(1);
    cfg[3] = 12'd80; apply_cfg();
    full_pkt(3'd3, 3, 4'd4, 1'b1, 0, 48'd1000, 48'd1250, sc);
    push_exp(sc + 2); idle(2);
    full_pkt(3'd3, 3, 4'd4, 1'b0, 1, 48'd2000, 48'd2100, sc);
    push_exp(sc + 2); idle(2);

    // Orphan middle, head, interrupting head, tail.
    dc = cyc; send_mid(); m_fmt = m_fmt + 32'd1; push_exp(dc + 1);
    send_head(3'd5, 48'd7, 48'd9);
    send_head(3'd5, 48'd100, 48'd300); m_fmt = m_fmt + 32'd1;
    send_tail(4'd7, 1'b1, 1'b1, sc);
    model_commit(3'd5, 32 - 7, 1'b1, 48'd100, 48'd300);
    push_exp(sc + 2); idle(2);

    // Latency saturation then a small latency that must not lower the max.
    full_pkt(3'd6, 1, 4'd0, 1'b1, 2, 48'h0001_0000_0000, 48'd5, sc);
    push_exp(sc + 2); idle(2);
    full_pkt(3'd6, 0, 4'd0, 1'b1, 0, 48'd90, 48'd100, sc);
    push_exp(sc + 2); idle(2);

    // Counter clear coincident with a commit: the commit is lost.
    full_pkt(3'd0, 2, 4'd3, 1'b1, 0, 48'd10, 48'd40, sc);
    cnt_rst = 1'b1; tick(); model_clear();
    push_exp(sc + 2); idle(2);

    // Counter clear mid-packet leaves the packet in progress intact.
    full_pkt(3'd2, 0, 4'd0, 1'b1, 0, 48'd1, 48'd2, sc); push_exp(sc + 2); idle(2);
    send_head(3'd4, 48'd50, 48'd80);
    cnt_rst = 1'b1; dc = cyc; send_mid(); model_clear(); push_exp(dc + 1);
    send_tail(4'd2, 1'b1, 1'b1, sc);
    model_commit(3'd4, 32 + 16 - 2, 1'b1, 48'd50, 48'd80);
    push_exp(sc + 2); idle(2);

    // Reset in the middle of a packet, then a clean flow-1 packet.
    send_head(3'd2, 48'd0, 48'd3); send_mid();
    rst = 1'b1; dc = cyc; tick(); model_clear(); push_exp(dc + 1); idle(1);
    full_pkt(3'd1, 1, 4'd0, 1'b1, 1, 48'd500, 48'd520, sc);
    push_exp(sc + 2); idle(2);

    // Randomised phase with per-flow length configuration.
    for (int k = 0; k < 8; k++) begin
      cfg_m[k]   = $urandom_range(0, 3);
      cfg_inv[k] = 4'($urandom_range(0, 15));
      cfg[k]     = 12'(32 + 16 * cfg_m[k] - int'(cfg_inv[k]));
    end
    apply_cfg();
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          rand_pkt(1'b0, sc); push_exp(sc + 2); idle(2);
        end
        2: begin
          dc = cyc; send_mid(); m_fmt = m_fmt + 32'd1; push_exp(dc + 1);
          repeat ($urandom_range(0, 2)) begin
            in_pam_data_valid_wr = 1'b1; in_pam_data_valid = 1'($urandom_range(0, 1));
            send_mid();
          end
          send_tail(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1, sc);
          idle(2);
        end
        3: begin
          send_tail(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1, dc);
          m_fmt = m_fmt + 32'd1; push_exp(dc + 1);
          send_status(1'b1, sc); idle(2);
        end
        4: begin
          send_head(3'($urandom_range(0, 7)), 48'($urandom()), ts_now);
          if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 2)) send_mid();
          else send_tail(4'($urandom_range(0, 15)), 1'b0, 1'b0, sc);
          m_fmt = m_fmt + 32'd1;
          rand_pkt(1'b0, sc); push_exp(sc + 2); idle(2);
        end
        default: begin
          rand_pkt(1'b1, sc); push_exp(sc + 2);
          rand_pkt(1'b0, sc2); push_exp(sc2 + 2); idle(2);
        end
      endcase
    end

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
